// File: rtl/register_file_sb_if.sv
// Bundle between decode/writeback and the busy-scoreboarded register file.
// The master side issues reads, issues and writebacks; the slave is the register file.
interface register_file_sb_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned LED_W = 6
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            reg_write;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] data;
  logic [LED_W-1:0] led;

  modport master (
    output rs1, rs2, issue_valid, issue_rd, reg_write, rd, data,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, led
  );

  modport slave (
    input  rs1, rs2, issue_valid, issue_rd, reg_write, rd, data,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, led
  );
endinterface

// File: rtl/register_file_sb.sv
// Integer register file (x0 = 0) with a per-register busy scoreboard and an active-low LED mirror.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_sb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned LED_REG = 1,
  parameter int unsigned LED_W   = 6
) (
  input logic               clock,
  input logic               reset_n,
  register_file_sb_if.slave bus
);
  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] LedIdx = AW'(LED_REG);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wr_en;
  logic             iss_en;
  logic [XLEN-1:0]  rs1_stored;
  logic [XLEN-1:0]  rs2_stored;

  assign wr_en  = bus.reg_write && (bus.rd != '0);
  assign iss_en = bus.issue_valid && (bus.issue_rd != '0);

  // Set is applied after clear so a newer producer on the same index keeps the bit high.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[bus.rd] = 1'b0;
    end
    if (iss_en) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[bus.rd] <= bus.data;
      end
      busy_q <= busy_d;
    end
  end

  assign rs1_stored = (bus.rs1 == '0) ? '0 : regs_q[bus.rs1];
  assign rs2_stored = (bus.rs2 == '0) ? '0 : regs_q[bus.rs2];

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  assign fwd1 = wr_en && (bus.rd == bus.rs1);
  assign fwd2 = wr_en && (bus.rd == bus.rs2);

  // A forwarded operand is ready unless the same cycle also issues a new producer for it.
  always_comb begin
    bus.rs1_data = fwd1 ? bus.data : rs1_stored;
    bus.rs2_data = fwd2 ? bus.data : rs2_stored;
    bus.rs1_busy = fwd1 ? (iss_en && (bus.issue_rd == bus.rs1)) : busy_q[bus.rs1];
    bus.rs2_busy = fwd2 ? (iss_en && (bus.issue_rd == bus.rs2)) : busy_q[bus.rs2];
  end
`else
  always_comb begin
    bus.rs1_data = rs1_stored;
    bus.rs2_data = rs2_stored;
    bus.rs1_busy = busy_q[bus.rs1];
    bus.rs2_busy = busy_q[bus.rs2];
  end
`endif

  assign bus.led = ~regs_q[LedIdx][LED_W-1:0];
endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: expectations are queued when stimulus is driven and
// popped when the corresponding output is sampled.
module tb_register_file_sb;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned LED_W = 6;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clock;
  logic reset_n;
  int   checks;
  int   passed;
  exp_t sb[$];

  register_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .LED_W(LED_W)) bus ();

  register_file_sb #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .LED_REG(1),
    .LED_W  (LED_W)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $error("FAIL sb_underflow: observed %h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.reg_write   = 1'b0;
    bus.rd          = '0;
    bus.data        = '0;
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    reset_n = 1'b0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    idle();

    #2;
    expect_val("init_rs1_data", 32'h0);
    expect_val("init_rs2_busy", 32'h0);
    expect_val("init_led", 32'h3F);
    check(bus.rs1_data);
    check(32'(bus.rs2_busy));
    check(32'(bus.led));
    #10 reset_n = 1'b1;
    tick();

    // Populate state, then assert reset mid-cycle with no clock edge.
    bus.reg_write = 1'b1; bus.rd = 5'd1; bus.data = 32'hFF;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd2;
    bus.rs1 = 5'd1; bus.rs2 = 5'd2;
    tick();
    idle();
    expect_val("pre_rst_rs1_data", 32'hFF);
    expect_val("pre_rst_rs2_busy", 32'h1);
    expect_val("pre_rst_led", 32'h00);
    check(bus.rs1_data);
    check(32'(bus.rs2_busy));
    check(32'(bus.led));
    #2 reset_n = 1'b0;
    #1;
    expect_val("async_rst_rs1_data", 32'h0);
    expect_val("async_rst_rs2_busy", 32'h0);
    expect_val("async_rst_led", 32'h3F);
    check(bus.rs1_data);
    check(32'(bus.rs2_busy));
    check(32'(bus.led));
    #2 reset_n = 1'b1;
    tick();

    bus.reg_write = 1'b1; bus.rd = 5'd5; bus.data = 32'hDEADBEEF; bus.rs1 = 5'd5;
    tick();
    idle();
    expect_val("wr_rd5", 32'hDEADBEEF);
    check(bus.rs1_data);

    bus.reg_write = 1'b1; bus.rd = 5'd0; bus.data = 32'h1234; bus.rs2 = 5'd0;
    tick();
    idle();
    expect_val("wr_x0_ignored", 32'h0);
    check(bus.rs2_data);

    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs1 = 5'd7; bus.rs2 = 5'd5;
    tick();
    idle();
    expect_val("issue7_busy", 32'h1);
    expect_val("rs2_5_busy", 32'h0);
    expect_val("rs2_5_data", 32'hDEADBEEF);
    check(32'(bus.rs1_busy));
    check(32'(bus.rs2_busy));
    check(bus.rs2_data);

    bus.reg_write = 1'b1; bus.rd = 5'd7; bus.data = 32'h77;
    tick();
    idle();
    expect_val("wb7_busy_clr", 32'h0);
    expect_val("wb7_data", 32'h77);
    check(32'(bus.rs1_busy));
    check(bus.rs1_data);

    bus.reg_write = 1'b1; bus.rd = 5'd7; bus.data = 32'h78;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    tick();
    idle();
    expect_val("same_idx_set_wins", 32'h1);
    expect_val("same_idx_data", 32'h78);
    check(32'(bus.rs1_busy));
    check(bus.rs1_data);

    bus.reg_write = 1'b1; bus.rd = 5'd7; bus.data = 32'h79;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd8; bus.rs2 = 5'd8;
    tick();
    idle();
    expect_val("diff_idx_clr7", 32'h0);
    expect_val("diff_idx_set8", 32'h1);
    expect_val("diff_idx_data7", 32'h79);
    check(32'(bus.rs1_busy));
    check(32'(bus.rs2_busy));
    check(bus.rs1_data);

    bus.issue_valid = 1'b1; bus.issue_rd = 5'd8;
    tick();
    tick();
    idle();
    expect_val("reissue8_busy", 32'h1);
    check(32'(bus.rs2_busy));
    bus.reg_write = 1'b1; bus.rd = 5'd8; bus.data = 32'h88;
    tick();
    idle();
    expect_val("reissue8_single_clear", 32'h0);
    check(32'(bus.rs2_busy));

    bus.reg_write = 1'b1; bus.rd = 5'd9; bus.data = 32'h99; bus.rs1 = 5'd9;
    tick();
    idle();
    expect_val("wb_nonbusy_busy", 32'h0);
    expect_val("wb_nonbusy_data", 32'h99);
    check(32'(bus.rs1_busy));
    check(bus.rs1_data);

    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.rs1 = 5'd0;
    tick();
    idle();
    expect_val("issue_x0_busy", 32'h0);
    check(32'(bus.rs1_busy));

    bus.reg_write = 1'b1; bus.rd = 5'd1; bus.data = 32'h0000_0015;
    #2;
    expect_val("led_before_edge", 32'h3F);
    check(32'(bus.led));
    tick();
    idle();
    expect_val("led_after_edge", 32'h2A);
    check(32'(bus.led));

    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    tick();
    idle();
    bus.reg_write = 1'b1; bus.rd = 5'd3; bus.data = 32'hA5; bus.rs1 = 5'd3;
    #2;
    expect_val("fwd_data_pre_edge", Bypass ? 32'hA5 : 32'h0);
    expect_val("fwd_busy_pre_edge", Bypass ? 32'h0 : 32'h1);
    check(bus.rs1_data);
    check(32'(bus.rs1_busy));
    tick();
    idle();
    expect_val("fwd_data_post_edge", 32'hA5);
    expect_val("fwd_busy_post_edge", 32'h0);
    check(bus.rs1_data);
    check(32'(bus.rs1_busy));

    bus.reg_write = 1'b1; bus.rd = 5'd3; bus.data = 32'h5A;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    #2;
    expect_val("fwd_issue_data_pre", Bypass ? 32'h5A : 32'hA5);
    expect_val("fwd_issue_busy_pre", Bypass ? 32'h1 : 32'h0);
    check(bus.rs1_data);
    check(32'(bus.rs1_busy));
    tick();
    idle();
    expect_val("fwd_issue_busy_post", 32'h1);
    expect_val("fwd_issue_data_post", 32'h5A);
    check(32'(bus.rs1_busy));
    check(bus.rs1_data);

    // Reset while a write and issue to x4 are pending; both must be dropped.
    bus.reg_write = 1'b1; bus.rd = 5'd4; bus.data = 32'h44;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; bus.rs1 = 5'd4; bus.rs2 = 5'd3;
    #2 reset_n = 1'b0;
    #1;
    expect_val("midop_rst_rs2_busy", 32'h0);
    check(32'(bus.rs2_busy));
    @(posedge clock);
    #2;
    idle();
    reset_n = 1'b1;
    tick();
    expect_val("midop_x4_data", 32'h0);
    expect_val("midop_x4_busy", 32'h0);
    expect_val("midop_x3_data", 32'h0);
    check(bus.rs1_data);
    check(32'(bus.rs1_busy));
    check(bus.rs2_data);

    bus.reg_write = 1'b1; bus.rd = 5'd4; bus.data = 32'h44;
    tick();
    idle();
    expect_val("post_rst_write", 32'h44);
    check(bus.rs1_data);

    checks++;
    assert (sb.size() == 0) passed++;
    else $error("FAIL sb_drain: observed %0d leftover expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
